// File: rtl/mprj_uart_pkg.sv
// Shared types and constants for the user-project UART transmitter.
package mprj_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 2;

endpackage

// File: rtl/mprj_uart_tx_if.sv
// Byte push port of the UART transmitter (valid/ready handshake).
interface mprj_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mprj_uart_tx_fifo.sv
// Byte FIFO with a separate level counter; ready depends only on registered level.
module mprj_uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic                     o_ready,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && (r_level != '0);
  assign o_ready = (r_level != FULL);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/mprj_uart_tx.sv
// 8N1 serial transmitter: FIFO-fed, per-frame latched bit-period divider.
module mprj_uart_tx
  import mprj_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mprj_uart_tx_if.slave          bus,
  input  logic [DIV_W-1:0]       clk_div,
  input  logic                   tx_en,
  output logic                   ser_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_e          r_state, w_state_nxt;
  logic [DIV_W-1:0]     r_div, w_div_nxt;
  logic [DIV_W-1:0]     r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0]     w_div_eff;
  logic [2:0]           r_idx, w_idx_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic                 r_ser, w_ser_nxt;
  logic                 r_busy;
  logic                 w_pop, w_start, w_can_start, w_bit_end, w_ready;
  logic [7:0]           w_head;
  logic [$clog2(DEPTH):0] w_level;

  mprj_uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.tx_valid),
    .i_data  (bus.tx_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_ready (w_ready),
    .o_level (w_level)
  );

  assign bus.tx_ready = w_ready;
  assign fifo_level   = w_level;
  assign ser_tx       = r_ser;
  assign busy         = r_busy;

  assign w_div_eff   = (clk_div < MIN_DIV_V) ? MIN_DIV_V : clk_div;
  assign w_can_start = (w_level != '0) && tx_en;
  assign w_bit_end   = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_ser_nxt   = r_ser;
    w_pop       = 1'b0;
    // A frame may start from IDLE, or straight out of a finishing stop bit.
    w_start     = w_can_start &&
                  ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    unique case (r_state)
      ST_IDLE: w_ser_nxt = 1'b1;
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_ser_nxt   = r_shift[0];
          w_cnt_nxt   = r_div - 1'b1;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = r_div - 1'b1;
          if (r_idx == LAST_BIT) begin
            w_state_nxt = ST_STOP;
            w_ser_nxt   = 1'b1;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_ser_nxt   = r_shift[1];
            w_idx_nxt   = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) w_state_nxt = ST_IDLE;
        else           w_cnt_nxt   = r_cnt - 1'b1;
      end
    endcase

    if (w_start) begin
      w_state_nxt = ST_START;
      w_pop       = 1'b1;
      w_shift_nxt = w_head;
      w_div_nxt   = w_div_eff;
      w_cnt_nxt   = w_div_eff - 1'b1;
      w_ser_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= MIN_DIV_V;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_ser   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_ser   <= w_ser_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_mprj_uart_tx.sv
// Directed bench for mprj_uart_tx: reset, framing, burst, tx_en gating, reset/clamp, loopback.
`timescale 1ns/1ps
module tb_mprj_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] clk_div;
  logic        tx_en;
  logic        ser_tx;
  logic        busy;
  logic [2:0]  fifo_level;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  push_q[$];
  logic        full_seen;

  mprj_uart_tx_if bus ();

  mprj_uart_tx #(.DEPTH(4), .DIV_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .clk_div    (clk_div),
    .tx_en      (tx_en),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #12.5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: offer the queue head, step past the edge, retire it if accepted.
  task automatic tick();
    logic acc;
    if (push_q.size() > 0) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = push_q[0];
    end else begin
      bus.tx_valid = 1'b0;
    end
    acc = bus.tx_valid && bus.tx_ready;
    @(posedge clk);
    #1;
    if (acc) void'(push_q.pop_front());
    if (push_q.size() == 0) bus.tx_valid = 1'b0;
    if (fifo_level == 3'd4 && !bus.tx_ready) full_seen = 1'b1;
  endtask

  // Entered with the first start-bit cycle currently visible on ser_tx.
  task automatic expect_frame(input logic [7:0] b, input int div, input int drop_at);
    int   n;
    logic e;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int c = 0; c < div; c++) begin
        chk($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, c), 32'(ser_tx), 32'(e));
        if (n == drop_at) tx_en = 1'b0;
        n++;
        tick();
      end
    end
  endtask

  task automatic uart_rx(input int idx, output logic [7:0] b);
    int w;
    w = 0;
    b = '0;
    while (ser_tx !== 1'b0 && w < 5000) begin
      tick();
      w++;
    end
    chk($sformatf("rx%0d_start_seen", idx), 32'(w < 5000), 32'd1);
    repeat (173) tick();
    chk($sformatf("rx%0d_start_mid", idx), 32'(ser_tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (347) tick();
      b[i] = ser_tx;
    end
    repeat (347) tick();
    chk($sformatf("rx%0d_stop", idx), 32'(ser_tx), 32'd1);
  endtask

  initial begin
    logic [7:0] rx_b;
    string      rx_s;

    rst_n        = 1'b0;
    tx_en        = 1'b1;
    clk_div      = 16'd4;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    full_seen    = 1'b0;

    // Reset
    repeat (5) tick();
    chk("rst_ser_during", 32'(ser_tx), 32'd1);
    rst_n = 1'b1;
    chk("rst_ser", 32'(ser_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (ser_tx !== 1'b1) bad++;
      end
      chk("idle_hold_low_cycles", 32'(bad), 32'd0);
    end

    // Single byte 0x41 at divider 4
    push_q.push_back(8'h41);
    tick();
    chk("single_level_after_push", 32'(fifo_level), 32'd1);
    chk("single_ser_before_start", 32'(ser_tx), 32'd1);
    chk("single_busy_before_start", 32'(busy), 32'd0);
    tick();
    chk("single_busy_rise", 32'(busy), 32'd1);
    expect_frame(8'h41, 4, -1);
    chk("single_busy_fall", 32'(busy), 32'd0);
    chk("single_level_end", 32'(fifo_level), 32'd0);

    // Burst of five, contiguous frames
    full_seen = 1'b0;
    push_q = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33};
    tick();
    chk("burst_level_first", 32'(fifo_level), 32'd1);
    tick();
    chk("burst_busy_rise", 32'(busy), 32'd1);
    expect_frame(8'h55, 4, -1);
    expect_frame(8'hAA, 4, -1);
    expect_frame(8'h0F, 4, -1);
    expect_frame(8'hF0, 4, -1);
    expect_frame(8'h33, 4, -1);
    chk("burst_full_seen", 32'(full_seen), 32'd1);
    chk("burst_busy_fall", 32'(busy), 32'd0);
    chk("burst_level_end", 32'(fifo_level), 32'd0);
    chk("burst_ready_end", 32'(bus.tx_ready), 32'd1);

    // tx_en dropped during the second of three queued frames
    push_q = '{8'h12, 8'h34, 8'h56};
    tick();
    tick();
    expect_frame(8'h12, 4, -1);
    expect_frame(8'h34, 4, 10);
    chk("en_ser_idle", 32'(ser_tx), 32'd1);
    chk("en_busy_idle", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("en_level_held", 32'(fifo_level), 32'd1);
    chk("en_ser_held", 32'(ser_tx), 32'd1);
    tx_en = 1'b1;
    tick();
    chk("en_restart_ser", 32'(ser_tx), 32'd0);
    chk("en_restart_busy", 32'(busy), 32'd1);
    expect_frame(8'h56, 4, -1);
    chk("en_busy_fall", 32'(busy), 32'd0);

    // Reset mid-frame
    tx_en  = 1'b0;
    push_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    repeat (4) tick();
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ready", 32'(bus.tx_ready), 32'd0);
    tx_en = 1'b1;
    tick();
    chk("mid_start_ser", 32'(ser_tx), 32'd0);
    chk("mid_level_queued", 32'(fifo_level), 32'd3);
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ser", 32'(ser_tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("post_rst_ser", 32'(ser_tx), 32'd1);

    // Divider clamp: 1 behaves as 2
    clk_div = 16'd1;
    push_q.push_back(8'h5A);
    tick();
    tick();
    chk("clamp_busy", 32'(busy), 32'd1);
    expect_frame(8'h5A, 2, -1);
    chk("clamp_busy_fall", 32'(busy), 32'd0);

    // Divider latched per frame
    clk_div = 16'd3;
    push_q.push_back(8'hC6);
    tick();
    tick();
    clk_div = 16'd5;
    expect_frame(8'hC6, 3, -1);
    chk("latch_busy_fall", 32'(busy), 32'd0);

    // Loopback at 115200 baud
    clk_div = 16'd347;
    rx_s    = "";
    push_q  = '{8'h4F, 8'h4B, 8'h0A};
    tick();
    uart_rx(0, rx_b);
    chk("rx0_byte", 32'(rx_b), 32'h4F);
    if (rx_b != 8'h0A) rx_s = $sformatf("%s%c", rx_s, rx_b);
    uart_rx(1, rx_b);
    chk("rx1_byte", 32'(rx_b), 32'h4B);
    if (rx_b != 8'h0A) rx_s = $sformatf("%s%c", rx_s, rx_b);
    uart_rx(2, rx_b);
    chk("rx2_byte", 32'(rx_b), 32'h0A);
    if (rx_b != 8'h0A) rx_s = $sformatf("%s%c", rx_s, rx_b);
    $display("uart monitor: %s", rx_s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
